// File: rtl/dlfloat_pkg.sv
// Shared widths, DLFloat field layout and transmit state encoding.
package dlfloat_pkg;

  localparam int DLF_W      = 16;
  localparam int BYTE_W     = 8;
  localparam int DLF_SIGN_W = 1;
  localparam int DLF_EXP_W  = 6;
  localparam int DLF_MANT_W = 9;

  typedef struct packed {
    logic [DLF_SIGN_W-1:0] sign;
    logic [DLF_EXP_W-1:0]  exp;
    logic [DLF_MANT_W-1:0] mant;
  } dlf_t;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_FIRST  = 2'd1,
    TX_SECOND = 2'd2
  } tx_state_t;

endpackage

// File: rtl/dlfloat_fifo.sv
// Result FIFO; full/empty come from the occupancy counter so the pointers
// may simply wrap (DEPTH must be a power of two, at least 2).
module dlfloat_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/dlfloat_result_tx.sv
// Queues 16-bit DLFloat results and streams each as two bytes over a
// valid/ready byte interface, refilling the hold register without a bubble.
module dlfloat_result_tx
  import dlfloat_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    res_valid,
  input  logic [DLF_W-1:0]        res_data,
  output logic                    res_ready,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [DLF_W-1:0]   r_hold;
  logic [DLF_W-1:0]   w_head;
  logic [CW-1:0]      w_count;
  logic               w_push;
  logic               w_pop;
  logic [BYTE_W-1:0]  w_byte_first;
  logic [BYTE_W-1:0]  w_byte_second;

  assign res_ready = (w_count < CW'(DEPTH));
  assign w_push    = res_valid && res_ready;

  dlfloat_fifo #(
    .W     (DLF_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (res_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (w_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = TX_FIRST;
        end
      end
      TX_FIRST: begin
        if (tx_ready) w_state_nxt = TX_SECOND;
      end
      TX_SECOND: begin
        // Reload straight from the FIFO head so back-to-back words stream
        // with no idle cycle between them.
        if (tx_ready) begin
          if (w_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = TX_FIRST;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_hold <= w_head;
    end
  end

  assign w_byte_first  = (MSB_FIRST != 0) ? r_hold[15:8] : r_hold[7:0];
  assign w_byte_second = (MSB_FIRST != 0) ? r_hold[7:0]  : r_hold[15:8];

  always_comb begin
    tx_data = '0;
    case (r_state)
      TX_FIRST:  tx_data = w_byte_first;
      TX_SECOND: tx_data = w_byte_second;
      default:   tx_data = '0;
    endcase
  end

  assign tx_valid   = (r_state != TX_IDLE);
  assign tx_last    = (r_state == TX_SECOND);
  assign fifo_count = w_count;
  assign busy       = (r_state != TX_IDLE) || (w_count != '0);

endmodule
